// File: rtl/mac_arbiter.sv
// mac_arbiter: two-requester round-robin front end for a shared complex MAC.
// A single transaction runs at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// The operands are latched when the request is granted. The result is
// captured on a rising edge of mac_ready. A WAIT that runs too long is
// aborted with err.
module mac_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] xa0,
  input  logic [31:0] xa1,
  input  logic [31:0] ya0,
  input  logic [31:0] ya1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [19:0] res,
  output logic        err,
  output logic        mac_start,
  output logic [31:0] mac_x,
  output logic [31:0] mac_y,
  input  logic [19:0] mac_res,
  input  logic        mac_ready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, nxt;
  logic            owner, last_served, mrdy_q, err_q;
  logic [CW-1:0]   cnt;
  logic [1:0]      req, gnt_v, done_v;
  logic [1:0][31:0] xv, yv;
  logic            win, rdy_edge, tmo;

  assign req = {req1, req0};
  assign xv  = {xa1, xa0};
  assign yv  = {ya1, ya0};

  // On a tie, the requester that was not served last wins.
  assign win      = (&req) ? ~last_served : req[1];
  assign rdy_edge = mac_ready & ~mrdy_q;
  assign tmo      = (cnt == CNT_LAST);

  assign {gnt1, gnt0}   = gnt_v;
  assign {done1, done0} = done_v;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next state. A ready edge is checked before the timeout, so an edge in the final cycle is a success.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|req) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (rdy_edge || tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, owner tracking, wait counter, result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      mrdy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt         <= '0;
      res         <= '0;
      mac_x       <= '0;
      mac_y       <= '0;
    end else begin
      mrdy_q <= mac_ready;
      cnt    <= '0;
      case (state)
        IDLE: if (|req) begin
          owner <= win;
          mac_x <= xv[win];
          mac_y <= yv[win];
          err_q <= 1'b0;
        end
        WAIT: begin
          if (rdy_edge)  res   <= mac_res;
          else if (tmo)  err_q <= 1'b1;
          else           cnt   <= cnt + CW'(1);
        end
        DONE: last_served <= owner;
        default: ;
      endcase
    end
  end

  // Outputs: single-cycle pulses decoded from the current state
  always_comb begin
    gnt_v     = '0;
    done_v    = '0;
    mac_start = 1'b0;
    err       = 1'b0;
    case (state)
      ISSUE: begin
        mac_start    = 1'b1;
        gnt_v[owner] = 1'b1;
      end
      DONE: begin
        done_v[owner] = 1'b1;
        err           = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT-state cycles before the transaction is aborted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  requester N has a transaction pending; held high until gntN.
REQ-005 xa0, xa1  input  32 each  requester N X operands {X0,X1,X2,X3}; each byte is {real[3:0],imag[3:0]}.
REQ-006 ya0, ya1  input  32 each  requester N Y operands; same packing as xa.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: requester N operands accepted.
REQ-008 done0, done1  output  1 each  one-cycle pulse: requester N result valid on res.
REQ-009 res  output  20  {real[9:0],imag[9:0]}, signed, registered copy of the MAC result.
REQ-010 err  output  1  high with doneN when the transaction timed out.
REQ-011 mac_start  output  1  start pulse to the shared MAC.
REQ-012 mac_x, mac_y  output  32 each  latched operands driven to the MAC, same packing as xa/ya.
REQ-013 mac_res  input  20  MAC result, same packing as res.
REQ-014 mac_ready  input  1  MAC ready level.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one state is active per cycle.
REQ-016 IDLE: if any req is high at the clock edge, the FSM shall go to ISSUE, latch the winner's xa/ya into mac_x/mac_y, and record the winner in owner.
REQ-017 Arbitration: a single requester shall win; when both request, the requester not equal to last_served shall win (round-robin).
REQ-018 ISSUE lasts exactly 1 cycle, with mac_start=1 and gnt[owner]=1; next state is WAIT.
REQ-019 WAIT: on a mac_ready rising edge (mac_ready=1 with the registered mac_ready from the previous cycle =0), the FSM shall capture mac_res into res and go to DONE.
REQ-020 WAIT: a cycle counter starts at 0 on entry; when it reaches TIMEOUT-1 with no edge, the FSM shall go to DONE with err set and res unchanged.
REQ-021 DONE lasts exactly 1 cycle, with done[owner]=1; err=1 only on the timeout path; last_served<=owner; next state is IDLE.
REQ-022 Requests are ignored outside IDLE; a req still high on return to IDLE is a new transaction.
REQ-023 Latency (normal path): req sampled at edge t -> gnt/mac_start in cycle t+1 -> WAIT from t+2 -> done exactly 1 cycle after the cycle in which the ready edge is sampled.
REQ-024 mac_x/mac_y shall hold stable from ISSUE through DONE.
REQ-025 A mac_ready edge coinciding with the counter's final cycle is a success: the edge takes priority over the timeout.
REQ-026 res holds its value between transactions; gnt, done, err and mac_start are 0 in every cycle except those stated above.

Reset
REQ-027 rst low shall immediately force state=IDLE, last_served=1 (so req0 wins the first tie), counter=0, and all outputs (including res, mac_x, mac_y) to 0.
REQ-028 A reset mid-transaction shall abandon it: no done pulse, and no pending state is retained after release.
REQ-029 The first clock edge after rst rises shall be treated as an IDLE sample.

Verification
REQ-030 Single request: req0=1, xa0=32'h12121212, ya0=32'h34343434 with the real MAC -> one gnt0 pulse, one mac_start pulse, then done0 with res real=-20, imag=40, err=0.
REQ-031 Tie: req0=req1=1 after reset -> requester 0 served first, then requester 1; with xa1=ya1=32'h77777777, done1 shows res real=0, imag=392.
REQ-032 Fairness: both req held high for 6 transactions -> grants strictly alternate 0,1,0,1,0,1; no gnt pulse outside ISSUE.
REQ-033 Timeout: mock MAC holds mac_ready=0, TIMEOUT=64 -> done pulses exactly 64 cycles after WAIT entry with err=1 and res unchanged.
REQ-034 Stale ready: mac_ready held high before and through ISSUE -> no capture until mac_ready falls and rises again.
REQ-035 Reset mid-WAIT: rst pulled low during WAIT -> all outputs 0 at once, no doneN, and the next tie after release goes to requester 0.
